// File: rtl/pwm_duty_ramp_ctrl.sv
// Duty-cycle sequencer for the PWM generator: takes targets over valid/ready and
// ramps duty_out one LSB per RAMP_DIV periods, updating only at period boundaries.
// Define PWM_FAULT_EN to add the active-low fault_n input and the FAULT state.
module pwm_duty_ramp_ctrl #(
  parameter int unsigned DUTY_W   = 3,
  parameter int unsigned RAMP_DIV = 4
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef PWM_FAULT_EN
  input  logic              fault_n,
`endif
  input  logic              enable,
  input  logic              tgt_valid,
  output logic              tgt_ready,
  input  logic [DUTY_W-1:0] tgt_duty,
  output logic [DUTY_W-1:0] duty_out,
  output logic              period_tick,
  output logic              at_target,
  output logic              busy
);

  localparam logic [DUTY_W-1:0] DUTY_MAX = '1;
  localparam logic [7:0]        DIV_LAST = 8'(RAMP_DIV - 1);

`ifdef PWM_FAULT_EN
  typedef enum logic [2:0] {S_IDLE, S_RAMP, S_HOLD, S_STOP, S_FAULT} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_RAMP, S_HOLD, S_STOP} state_t;
`endif

  state_t            state_q, state_d;
  logic [DUTY_W-1:0] cnt_q;
  logic [7:0]        div_q, div_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [DUTY_W-1:0] tgt_q, tgt_d;
  logic [DUTY_W-1:0] pend_q, pend_d;
  logic              pend_vld_q, pend_vld_d;
  logic              boundary;
  logic              step_due;

  // The edge that ends a period_tick cycle is the only edge where duty/target may move.
  assign boundary = (cnt_q == DUTY_MAX);
  assign step_due = boundary && (div_q == DIV_LAST);

`ifdef PWM_FAULT_EN
  assign tgt_ready = !pend_vld_q && (state_q != S_FAULT);
`else
  assign tgt_ready = !pend_vld_q;
`endif

  assign duty_out    = duty_q;
  assign period_tick = boundary;
  assign busy        = (state_q == S_RAMP) || (state_q == S_STOP);
  assign at_target   = (state_q == S_HOLD) && (duty_q == tgt_q);

  always_comb begin
    state_d    = state_q;
    duty_d     = duty_q;
    div_d      = div_q;
    tgt_d      = tgt_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;

    // Transfer and promotion never coincide: a transfer needs an empty pending slot.
    if (tgt_valid && tgt_ready) begin
      pend_vld_d = 1'b1;
      pend_d     = tgt_duty;
    end
    if (boundary && pend_vld_q) begin
      tgt_d      = pend_q;
      pend_vld_d = 1'b0;
    end

    if (boundary && ((state_q == S_RAMP) || (state_q == S_STOP))) begin
      div_d = step_due ? '0 : div_q + 8'd1;
    end

    case (state_q)
      S_IDLE: begin
        duty_d = '0;
        if (enable) state_d = S_RAMP;
      end
      S_RAMP: begin
        if (!enable) begin
          state_d = S_STOP;
        end else if (boundary) begin
          if (duty_q == tgt_q) begin
            state_d = S_HOLD;
          end else if (step_due) begin
            // Strict compare means +1 never wraps at max and -1 never wraps at 0.
            duty_d = (duty_q < tgt_q) ? duty_q + 1'b1 : duty_q - 1'b1;
            if (duty_d == tgt_q) state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (!enable)              state_d = S_STOP;
        else if (duty_q != tgt_q) state_d = S_RAMP;
      end
      S_STOP: begin
        if (enable) begin
          state_d = S_RAMP;
        end else if (boundary) begin
          if (duty_q == '0) begin
            state_d = S_IDLE;
          end else if (step_due) begin
            duty_d = duty_q - 1'b1;
            if (duty_d == '0) state_d = S_IDLE;
          end
        end
      end
`ifdef PWM_FAULT_EN
      S_FAULT: begin
        duty_d = '0;
        if (!enable && fault_n) state_d = S_IDLE;
      end
`endif
      default: begin
        state_d = S_IDLE;
        duty_d  = '0;
      end
    endcase

`ifdef PWM_FAULT_EN
    // Fault overrides everything, including the boundary-only update rule.
    if (!fault_n) begin
      state_d    = S_FAULT;
      duty_d     = '0;
      pend_vld_d = 1'b0;
    end
`endif

    if (state_d != state_q) div_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      div_q      <= '0;
      duty_q     <= '0;
      tgt_q      <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_q + 1'b1;
      div_q      <= div_d;
      duty_q     <= duty_d;
      tgt_q      <= tgt_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
    end
  end

endmodule

// File: tb/tb_pwm_duty_ramp_ctrl.sv
// Directed bench for pwm_duty_ramp_ctrl (DUTY_W=3, RAMP_DIV=4: 8-clock periods, 32-clock steps).
// Fault scenario is compiled only when PWM_FAULT_EN is defined.
module tb_pwm_duty_ramp_ctrl;

  localparam int unsigned DUTY_W   = 3;
  localparam int unsigned RAMP_DIV = 4;
  localparam int          STEP_CLKS = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              enable;
  logic              tgt_valid;
  logic              tgt_ready;
  logic [DUTY_W-1:0] tgt_duty;
  logic [DUTY_W-1:0] duty_out;
  logic              period_tick;
  logic              at_target;
  logic              busy;
`ifdef PWM_FAULT_EN
  logic              fault_n = 1'b1;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pwm_duty_ramp_ctrl #(
    .DUTY_W  (DUTY_W),
    .RAMP_DIV(RAMP_DIV)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef PWM_FAULT_EN
    .fault_n    (fault_n),
`endif
    .enable     (enable),
    .tgt_valid  (tgt_valid),
    .tgt_ready  (tgt_ready),
    .tgt_duty   (tgt_duty),
    .duty_out   (duty_out),
    .period_tick(period_tick),
    .at_target  (at_target),
    .busy       (busy)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_tick(input string name);
    int n = 0;
    while (period_tick !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (period_tick !== 1'b1) begin
      errors++;
      $display("FAIL %s: period_tick got %b expected 1 within 20 clocks", name, period_tick);
    end
  endtask

  task automatic send(input logic [DUTY_W-1:0] d, input string name);
    int n = 0;
    while (tgt_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (tgt_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s: tgt_ready got %b expected 1", name, tgt_ready);
    end
    tgt_valid = 1'b1;
    tgt_duty  = d;
    tick();
    tgt_valid = 1'b0;
  endtask

  // Follows duty_out until it equals final_val; every change must come right after a
  // period_tick cycle, be exactly dir, and be 32 clocks after the previous change.
  task automatic watch_ramp(input int dir, input int final_val, input string name);
    int last = -1;
    int prev = int'(duty_out);
    logic prev_tick = period_tick;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      tick();
      if (int'(duty_out) != prev) begin
        checks++;
        if (prev_tick !== 1'b1) begin
          errors++;
          $display("FAIL %s_midperiod: duty %0d->%0d got change off-boundary expected boundary only", name, prev, duty_out);
        end
        checks++;
        if (int'(duty_out) != prev + dir) begin
          errors++;
          $display("FAIL %s_step: duty got %0d expected %0d", name, duty_out, prev + dir);
        end
        if (last >= 0) begin
          checks++;
          if (cyc - last != STEP_CLKS) begin
            errors++;
            $display("FAIL %s_interval: got %0d clocks expected %0d", name, cyc - last, STEP_CLKS);
          end
        end
        last = cyc;
        prev = int'(duty_out);
      end
      prev_tick = period_tick;
      if (int'(duty_out) == final_val) break;
    end
    checks++;
    if (int'(duty_out) != final_val) begin
      errors++;
      $display("FAIL %s_final: duty got %0d expected %0d", name, duty_out, final_val);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; tgt_valid = 1'b0; tgt_duty = '0;
    repeat (3) tick();
    checks++; if (duty_out !== 3'd0)  begin errors++; $display("FAIL rst_duty: got %0d expected 0", duty_out); end
    checks++; if (tgt_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b expected 1", tgt_ready); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    checks++; if (at_target !== 1'b0) begin errors++; $display("FAIL rst_at_target: got %b expected 0", at_target); end
    checks++; if (period_tick !== 1'b0) begin errors++; $display("FAIL rst_tick: got %b expected 0", period_tick); end
    rst_n = 1'b1;
    repeat (6) tick();
    checks++; if (period_tick !== 1'b0) begin errors++; $display("FAIL tick_early: got %b expected 0 at count 6", period_tick); end
    tick();
    checks++; if (period_tick !== 1'b1) begin errors++; $display("FAIL tick_at7: got %b expected 1 at count 7", period_tick); end
    tick();
    checks++; if (period_tick !== 1'b0) begin errors++; $display("FAIL tick_wrap: got %b expected 0 at count 0", period_tick); end
  endtask

  task automatic test_ramp_up();
    send(3'd5, "ru_send");
    checks++; if (tgt_ready !== 1'b0) begin errors++; $display("FAIL ru_pending: tgt_ready got %b expected 0", tgt_ready); end
    wait_tick("ru_sync");
    tick();
    checks++; if (tgt_ready !== 1'b1) begin errors++; $display("FAIL ru_promote: tgt_ready got %b expected 1", tgt_ready); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL ru_idle_busy: got %b expected 0", busy); end
    enable = 1'b1;
    tick();
    checks++; if (busy !== 1'b1)      begin errors++; $display("FAIL ru_busy: got %b expected 1", busy); end
    watch_ramp(1, 5, "ru");
    checks++; if (at_target !== 1'b1) begin errors++; $display("FAIL ru_at_target: got %b expected 1", at_target); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL ru_hold_busy: got %b expected 0", busy); end
  endtask

  task automatic test_retarget();
    wait_tick("rt_sync");
    tick();
    tgt_valid = 1'b1; tgt_duty = 3'd2;
    tick();
    tgt_duty = 3'd7;
    checks++; if (tgt_ready !== 1'b0) begin errors++; $display("FAIL rt_stall: tgt_ready got %b expected 0", tgt_ready); end
    repeat (2) tick();
    checks++; if (tgt_ready !== 1'b0) begin errors++; $display("FAIL rt_stall2: tgt_ready got %b expected 0", tgt_ready); end
    checks++; if (duty_out !== 3'd5)  begin errors++; $display("FAIL rt_hold_duty: got %0d expected 5", duty_out); end
    checks++; if (at_target !== 1'b1) begin errors++; $display("FAIL rt_hold_at: got %b expected 1", at_target); end
    tgt_valid = 1'b0;
    wait_tick("rt_bnd");
    tick();
    checks++; if (tgt_ready !== 1'b1) begin errors++; $display("FAIL rt_ready_back: got %b expected 1", tgt_ready); end
    checks++; if (at_target !== 1'b0) begin errors++; $display("FAIL rt_newtgt_at: got %b expected 0", at_target); end
    tick();
    checks++; if (busy !== 1'b1)      begin errors++; $display("FAIL rt_busy: got %b expected 1", busy); end
    watch_ramp(-1, 4, "rt_down");
    send(3'd7, "rt_send7");
    watch_ramp(1, 7, "rt_up");
    checks++; if (at_target !== 1'b1) begin errors++; $display("FAIL rt_at7: got %b expected 1", at_target); end
  endtask

  task automatic test_stop();
    send(3'd6, "st_send6");
    watch_ramp(-1, 6, "st_to6");
    checks++; if (at_target !== 1'b1) begin errors++; $display("FAIL st_at6: got %b expected 1", at_target); end
    enable = 1'b0;
    tick();
    checks++; if (busy !== 1'b1)      begin errors++; $display("FAIL st_busy: got %b expected 1", busy); end
    checks++; if (at_target !== 1'b0) begin errors++; $display("FAIL st_at: got %b expected 0", at_target); end
    watch_ramp(-1, 0, "st_down");
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL st_idle_busy: got %b expected 0", busy); end
    repeat (10) tick();
    checks++; if (duty_out !== 3'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL st_idle: duty/busy got %0d/%b expected 0/0", duty_out, busy);
    end
    enable = 1'b1;
    watch_ramp(1, 6, "st_restart");
    checks++; if (at_target !== 1'b1) begin errors++; $display("FAIL st_restart_at: got %b expected 1", at_target); end
    enable = 1'b0;
    watch_ramp(-1, 3, "st_partial");
    enable = 1'b1;
    tick();
    checks++; if (busy !== 1'b1 || duty_out !== 3'd3) begin
      errors++; $display("FAIL st_resume: busy/duty got %b/%0d expected 1/3", busy, duty_out);
    end
    watch_ramp(1, 6, "st_resume");
    checks++; if (at_target !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL st_resume_hold: at/busy got %b/%b expected 1/0", at_target, busy);
    end
  endtask

  task automatic test_saturate();
    send(3'd7, "sa_send7");
    watch_ramp(1, 7, "sa_up");
    send(3'd7, "sa_again7");
    for (int i = 0; i < 48; i++) begin
      tick();
      checks++;
      if (duty_out !== 3'd7 || at_target !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL sa_max_stable: duty/at/busy got %0d/%b/%b expected 7/1/0", duty_out, at_target, busy);
        break;
      end
    end
    send(3'd0, "sa_send0");
    watch_ramp(-1, 0, "sa_down");
    checks++; if (at_target !== 1'b1) begin errors++; $display("FAIL sa_at0: got %b expected 1", at_target); end
    send(3'd0, "sa_again0");
    for (int i = 0; i < 48; i++) begin
      tick();
      checks++;
      if (duty_out !== 3'd0 || at_target !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL sa_zero_stable: duty/at/busy got %0d/%b/%b expected 0/1/0", duty_out, at_target, busy);
        break;
      end
    end
  endtask

  task automatic test_reset_midramp();
    send(3'd6, "rm_send6");
    watch_ramp(1, 3, "rm_up");
    send(3'd1, "rm_send1");
    checks++; if (tgt_ready !== 1'b0) begin errors++; $display("FAIL rm_pending: tgt_ready got %b expected 0", tgt_ready); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (duty_out !== 3'd0)  begin errors++; $display("FAIL rm_duty: got %0d expected 0", duty_out); end
    checks++; if (tgt_ready !== 1'b1) begin errors++; $display("FAIL rm_ready: got %b expected 1", tgt_ready); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL rm_busy: got %b expected 0", busy); end
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (busy !== 1'b1)      begin errors++; $display("FAIL rm_t0_ramp: busy got %b expected 1", busy); end
    wait_tick("rm_sync");
    tick();
    checks++; if (busy !== 1'b0 || at_target !== 1'b1 || duty_out !== 3'd0) begin
      errors++; $display("FAIL rm_t0_hold: busy/at/duty got %b/%b/%0d expected 0/1/0", busy, at_target, duty_out);
    end
    for (int i = 0; i < 48; i++) begin
      tick();
      checks++;
      if (duty_out !== 3'd0 || at_target !== 1'b1) begin
        errors++;
        $display("FAIL rm_discard: duty/at got %0d/%b expected 0/1", duty_out, at_target);
        break;
      end
    end
  endtask

`ifdef PWM_FAULT_EN
  task automatic test_fault();
    send(3'd4, "fa_send4");
    watch_ramp(1, 4, "fa_up");
    wait_tick("fa_sync");
    repeat (2) tick();
    fault_n = 1'b0;
    tick();
    checks++; if (duty_out !== 3'd0)  begin errors++; $display("FAIL fa_duty: got %0d expected 0", duty_out); end
    checks++; if (busy !== 1'b0 || at_target !== 1'b0 || tgt_ready !== 1'b0) begin
      errors++; $display("FAIL fa_flags: busy/at/ready got %b/%b/%b expected 0/0/0", busy, at_target, tgt_ready);
    end
    fault_n = 1'b1; enable = 1'b1;
    repeat (12) tick();
    checks++; if (duty_out !== 3'd0 || busy !== 1'b0 || tgt_ready !== 1'b0) begin
      errors++; $display("FAIL fa_stay: duty/busy/ready got %0d/%b/%b expected 0/0/0", duty_out, busy, tgt_ready);
    end
    enable = 1'b0;
    tick();
    checks++; if (tgt_ready !== 1'b1 || busy !== 1'b0 || duty_out !== 3'd0) begin
      errors++; $display("FAIL fa_exit: ready/busy/duty got %b/%b/%0d expected 1/0/0", tgt_ready, busy, duty_out);
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_ramp_up();
    test_retarget();
    test_stop();
    test_saturate();
    test_reset_midramp();
`ifdef PWM_FAULT_EN
    test_fault();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
